// File: rtl/servo_ramp.sv
// Slew-rate limiter feeding the PWM servo driver: moves position_o toward the accepted
// target by at most step_i LSBs per frame. Define SERVO_RAMP_CLAMP_EN to clamp targets to [MIN_POS, MAX_POS].
module servo_ramp #(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int FRAME_MS   = 20,
    parameter int INIT_POS   = 128,
    parameter int MIN_POS    = 0,
    parameter int MAX_POS    = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] target_i,
    input  logic         target_valid_i,
    output logic         target_ready_o,
    input  logic [N-1:0] step_i,
    output logic [N-1:0] position_o,
    output logic         en_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int MS   = 1_000_000 / CLK_PER_NS;
    localparam int MS_W = (MS > 1) ? $clog2(MS) : 1;
    localparam int FR_W = (FRAME_MS > 1) ? $clog2(FRAME_MS) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAME_MS - 1);
    localparam logic [N-1:0]    INIT_L  = N'(INIT_POS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [MS_W-1:0] ms_cnt_r;
    logic [FR_W-1:0] frame_cnt_r;
    logic [N-1:0]    position_r, target_r, pos_nxt_s, tgt_nxt_s;
    logic            done_r, done_nxt_s, en_r;
    logic            ms_tick_s, frame_tick_s, target_ready_s, accept_s, snap_s;
    logic [N-1:0]    tgt_in_s;
    logic [N:0]      diff_s, mag_s;

    function automatic logic [N-1:0] clamp_target(input logic [N-1:0] t);
`ifdef SERVO_RAMP_CLAMP_EN
        logic [N-1:0] res;
        if (t < N'(MIN_POS)) begin
            res = N'(MIN_POS);
        end else if (t > N'(MAX_POS)) begin
            res = N'(MAX_POS);
        end else begin
            res = t;
        end
        return res;
`else
        return t;
`endif
    endfunction

    assign ms_tick_s      = en_i && (ms_cnt_r == MS_LAST);
    assign frame_tick_s   = ms_tick_s && (frame_cnt_r == FR_LAST);
    assign target_ready_s = en_i && (state_r == ST_IDLE) && !rst_i;
    assign accept_s       = target_valid_i && target_ready_s;
    assign tgt_in_s       = clamp_target(target_i);

    // Magnitude of target-position in N+1 bits; the sign bit picks the step direction
    assign diff_s = {1'b0, target_r} - {1'b0, position_r};
    assign mag_s  = diff_s[N] ? (~diff_s + {{N{1'b0}}, 1'b1}) : diff_s;
    assign snap_s = (step_i == '0) || (mag_s <= {1'b0, step_i});

    // Millisecond and frame counters, held at zero while the block is disabled
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            ms_cnt_r    <= '0;
            frame_cnt_r <= '0;
        end else if (ms_tick_s) begin
            ms_cnt_r    <= '0;
            frame_cnt_r <= frame_tick_s ? '0 : frame_cnt_r + 1'b1;
        end else begin
            ms_cnt_r    <= ms_cnt_r + 1'b1;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (tgt_in_s != position_r)) begin
                    state_nxt_s = ST_RAMP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (frame_tick_s && snap_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RAMP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next position, target and done pulse
    always_comb begin
        pos_nxt_s  = position_r;
        tgt_nxt_s  = target_r;
        done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    tgt_nxt_s  = tgt_in_s;
                    done_nxt_s = (tgt_in_s == position_r);
                end else begin
                    tgt_nxt_s  = target_r;
                end
            end
            ST_RAMP: begin
                if (!frame_tick_s) begin
                    pos_nxt_s = position_r;
                end else if (snap_s) begin
                    pos_nxt_s  = target_r;
                    done_nxt_s = 1'b1;
                end else if (diff_s[N]) begin
                    pos_nxt_s = position_r - step_i;
                end else begin
                    pos_nxt_s = position_r + step_i;
                end
            end
            default: begin
                pos_nxt_s = position_r;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            position_r <= INIT_L;
            target_r   <= INIT_L;
            done_r     <= 1'b0;
            en_r       <= 1'b0;
        end else begin
            position_r <= pos_nxt_s;
            target_r   <= tgt_nxt_s;
            done_r     <= done_nxt_s;
            en_r       <= en_i;
        end
    end

    assign target_ready_o = target_ready_s;
    assign position_o     = position_r;
    assign en_o           = en_r;
    assign busy_o         = (state_r == ST_RAMP);
    assign done_o         = done_r;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp: MS=10 cycles, frame=200 cycles. A second instance with
// MAX_POS=180 covers the clamp option.
module tb_servo_ramp;

    localparam int CLK_NS = 100000;

    logic       clk = 1'b0;
    logic       rst, en, valid, valid_c;
    logic [7:0] target, step;
    logic       ready, en_o, busy, done;
    logic [7:0] pos;
    logic       ready_c, en_o_c, busy_c, done_c;
    logic [7:0] pos_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] step;
        logic [7:0] target;
        logic [7:0] exp_first;
        logic [7:0] exp_final;
        int         exp_frames;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    servo_ramp #(.CLK_PER_NS(CLK_NS)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .target_i(target), .target_valid_i(valid),
        .target_ready_o(ready), .step_i(step), .position_o(pos), .en_o(en_o),
        .busy_o(busy), .done_o(done)
    );

    servo_ramp #(.CLK_PER_NS(CLK_NS), .MAX_POS(180)) dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(en), .target_i(target), .target_valid_i(valid_c),
        .target_ready_o(ready_c), .step_i(step), .position_o(pos_c), .en_o(en_o_c),
        .busy_o(busy_c), .done_o(done_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic accept(input logic [7:0] t);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", ready, 1'b1);
        target = t;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic wait_step(output int n, output logic busy_all);
        logic [7:0] prev;
        prev     = pos;
        n        = 0;
        busy_all = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (pos == prev && !busy) busy_all = 1'b0;
        end while (pos == prev && n < 1000);
        if (n >= 1000) check("step_timeout", pos, prev + 8'd1);
    endtask

    task automatic run_ramp(input int idx, input vec_t v);
        int   n, frames;
        logic b;
        step = v.step;
        accept(v.target);
        check("vec_busy", busy, 1'b1);
        frames = 0;
        do begin
            wait_step(n, b);
            frames++;
            if (frames == 1) check($sformatf("vec%0d_first", idx), pos, v.exp_first);
            else check($sformatf("vec%0d_gap", idx), n, 200);
        end while (!done && frames < 20 && n < 1000);
        check($sformatf("vec%0d_final", idx), pos, v.exp_final);
        check($sformatf("vec%0d_frames", idx), frames, v.exp_frames);
        check($sformatf("vec%0d_done", idx), done, 1'b1);
        check($sformatf("vec%0d_ready", idx), ready, 1'b1);
        @(negedge clk);
        check($sformatf("vec%0d_done_pulse", idx), done, 1'b0);
    endtask

    int         n;
    logic       b;
    logic [7:0] first_c;
    logic       seen;

    initial begin
        vecs[0] = '{8'd50,  8'd5,   8'd78,  8'd5,   3};
        vecs[1] = '{8'd50,  8'd250, 8'd55,  8'd250, 5};
        vecs[2] = '{8'd255, 8'd0,   8'd0,   8'd0,   1};
        vecs[3] = '{8'd7,   8'd20,  8'd7,   8'd20,  3};
        vecs[4] = '{8'd1,   8'd22,  8'd21,  8'd22,  2};
        vecs[5] = '{8'd200, 8'd255, 8'd222, 8'd255, 2};
        vecs[6] = '{8'd128, 8'd0,   8'd127, 8'd0,   2};

        // Reset held with enable and valid asserted
        rst = 1'b1; en = 1'b1; valid = 1'b1; valid_c = 1'b0;
        target = 8'd50; step = 8'd10;
        repeat (2) begin
            @(negedge clk);
            check("rst_pos", pos, 8'd128);
            check("rst_en_o", en_o, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_ready", ready, 1'b0);
        end
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_en_o", en_o, 1'b1);
        check("post_rst_pos", pos, 8'd128);

        // Ramp up 128 -> 200 with step 10
        step = 8'd10;
        accept(8'd200);
        check("up_busy", busy, 1'b1);
        check("up_ready", ready, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            wait_step(n, b);
            check($sformatf("up_pos%0d", k), pos, (k < 8) ? 8'd128 + 8'(10 * k) : 8'd200);
            if (k > 1) check($sformatf("up_gap%0d", k), n, 200);
            check($sformatf("up_done%0d", k), done, (k == 8) ? 1'b1 : 1'b0);
            check($sformatf("up_ready%0d", k), ready, (k == 8) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        check("up_done_pulse", done, 1'b0);

        // Jump 200 -> 5 with step 0
        step = 8'd0;
        accept(8'd5);
        check("jump_busy", busy, 1'b1);
        wait_step(n, b);
        check("jump_pos", pos, 8'd5);
        check("jump_done", done, 1'b1);
        check("jump_busy_end", busy, 1'b0);
        check("jump_busy_held", b, 1'b1);
        @(negedge clk);
        check("jump_done_pulse", done, 1'b0);

        // Disable mid-ramp at 158
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step = 8'd10;
        accept(8'd200);
        repeat (3) wait_step(n, b);
        check("dis_pos3", pos, 8'd158);
        en = 1'b0;
        @(negedge clk);
        check("dis_en_o", en_o, 1'b0);
        check("dis_pos", pos, 8'd158);
        repeat (499) @(negedge clk);
        check("dis_hold_pos", pos, 8'd158);
        check("dis_hold_busy", busy, 1'b1);
        en = 1'b1;
        wait_step(n, b);
        check("resume_gap", n, 200);
        check("resume_pos", pos, 8'd168);
        for (int k = 0; k < 10 && !done; k++) wait_step(n, b);
        check("resume_final", pos, 8'd200);

        // Clamp instance, MAX_POS=180
        step = 8'd50;
        check("clamp_ready", ready_c, 1'b1);
        target = 8'd250; valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        check("clamp_busy", busy_c, 1'b1);
        seen = 1'b0; first_c = 8'd0; n = 0;
        while (!done_c && n < 2000) begin
            @(negedge clk);
            n++;
            if (!seen && pos_c != 8'd128) begin
                first_c = pos_c;
                seen    = 1'b1;
            end
        end
        check("clamp_first", first_c, 8'd178);
        check("clamp_done", done_c, 1'b1);
`ifdef SERVO_RAMP_CLAMP_EN
        check("clamp_final", pos_c, 8'd180);
`else
        check("clamp_final", pos_c, 8'd250);
`endif

        // Null target equal to current position
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        accept(8'd128);
        check("null_busy", busy, 1'b0);
        check("null_done", done, 1'b1);
        check("null_ready", ready, 1'b1);
        @(negedge clk);
        check("null_done_pulse", done, 1'b0);
        check("null_busy2", busy, 1'b0);
        check("null_pos", pos, 8'd128);

        // Table-driven ramps chained from 128
        for (int i = 0; i < 7; i++) run_ramp(i, vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Slew-rate limiter that sits directly upstream of the PWM servo driver. Accepts target positions over a valid/ready handshake and moves its position output toward the target by at most `step_i` LSBs per servo frame (default 20 ms). This avoids mechanical jerks and current spikes on large commands. `position_o` and `en_o` connect directly to the driver's position and enable inputs.

## Interface
Parameters:
- `CLK_PER_NS`, default 40: clock period in ns. One ms is `1_000_000/CLK_PER_NS` cycles, integer division.
- `N`, default 8: position width; must match the driver's `N`.
- `FRAME_MS`, default 20: update period in ms; must be 1 or greater.
- `INIT_POS`, default 128: reset position and reset target.
- `MIN_POS`, default 0: lower clamp bound. Used only when `SERVO_RAMP_CLAMP_EN` is defined.
- `MAX_POS`, default 255: upper clamp bound. Used only when `SERVO_RAMP_CLAMP_EN` is defined.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset; synchronous and active-high.
- `en_i` in 1: block enable.
- `target_i` in N: requested position.
- `target_valid_i` in 1: `target_i` is valid.
- `target_ready_o` out 1: block can accept a target.
- `step_i` in N: maximum change per frame. 0 means jump straight to the target.
- `position_o` out N: current position, feeds the driver.
- `en_o` out 1: driver enable.
- `busy_o` out 1: high while in RAMP.
- `done_o` out 1: one-cycle pulse when the target is reached.

## Operation
- **Reset (`rst_i`=1 at a clock edge).** Applies mid-ramp too; no partial step is completed.
  - `position_o`=INIT_POS, target register=INIT_POS, state=IDLE.
  - `en_o`=0, `done_o`=0, ms/frame counters=0.
  - `target_ready_o` is 0 while `rst_i` is high.
- **ms counter.** Counts 0 to `MS-1` then wraps, where `MS=1_000_000/CLK_PER_NS`. It pulses `ms_tick` on the wrap cycle.
- **Frame counter.** Counts `ms_tick` from 0 to `FRAME_MS-1`, then wraps. It pulses `frame_tick` on the cycle where both counters wrap.
- **Counter enable.** Both counters run freely while `en_i`=1. Both are held at 0 while `en_i`=0.
- **`target_ready_o`** = `en_i` && state==IDLE && !`rst_i`. It is combinational from registered state.
- **Handshake.** A target is accepted on any edge where `target_valid_i` && `target_ready_o`. The value is latched into the target register; with clamping enabled the clamped value is latched.
- **State IDLE.**
  - Accepted target ≠ `position_o`: go to RAMP.
  - Accepted target = `position_o`: stay in IDLE and pulse `done_o` on the next cycle.
- **State RAMP.**
  - On each `frame_tick`, compute `diff = target − position` in N+1-bit signed arithmetic.
  - If `step_i`==0 or |diff| ≤ `step_i`, then `position_o` ← target, go to IDLE, and pulse `done_o` on the next cycle.
  - Otherwise `position_o` ← `position_o` ± `step_i`, moving toward the target.
  - Overflow or wrap of `position_o` is impossible by construction.
- **`step_i` sampling.** `step_i` is sampled at each `frame_tick` and may change between frames.
- **`en_i`=0 during RAMP.** State stays in RAMP and the position freezes because no ticks occur. When `en_i` returns to 1, the ramp resumes and the next step comes one full frame later.
- **`en_o`** is `en_i` registered with 1-cycle latency, reset 0.

## Timing
- Handshake acceptance to RAMP (`busy_o`=1): 1 cycle.
- First step happens on the next `frame_tick`, which is at most FRAME_MS ms after acceptance. Later steps come every FRAME_MS·MS cycles.
- `position_o` updates on the edge that registers `frame_tick`. `done_o` is asserted on the following cycle, for exactly 1 cycle.
- `target_ready_o` is 0 from acceptance until the cycle after the final step.
- `en_i` falling edge to `en_o` low: 1 cycle. The driver therefore never sees enable without a stable position.

## Configuration
- **`SERVO_RAMP_CLAMP_EN` defined:** each accepted target is clamped to [MIN_POS, MAX_POS] before latching. An out-of-range target ramps to the bound and `done_o` fires there.
- **`SERVO_RAMP_CLAMP_EN` not defined:** the target is latched unmodified, and MIN_POS/MAX_POS are ignored.

## Test plan
All scenarios use a bench with `CLK_PER_NS`=100000, giving MS=10 cycles and a frame of 200 cycles.

1. **Reset.** Hold `rst_i`=1 for 2 cycles with `en_i`=1 and `target_valid_i`=1. Required: `position_o`=128, `en_o`=0, `busy_o`=0, `done_o`=0, `target_ready_o`=0 throughout. After release, `target_ready_o`=1 and `en_o`=1 one cycle later.
2. **Ramp up.** Set `step_i`=10 and accept target 200 from 128. Required:
   - `position_o` = 138, 148, …, 198, then 200 on 8 successive frame ticks, 200 cycles apart.
   - One `done_o` pulse after 200.
   - `target_ready_o`=0 until then.
3. **Jump.** Set `step_i`=0 and accept target 5 from 200. Required: `position_o`=5 at the first `frame_tick`, `done_o` on the next cycle, `busy_o` high for exactly until that tick.
4. **Disable mid-ramp.** Use `step_i`=10 and target 200. Drop `en_i` for 500 cycles after the 3rd step (position 158). Required:
   - `position_o` stays at 158 and `en_o`=0 one cycle after the drop.
   - After re-enable, the next step (168) comes exactly 200 cycles later.
5. **Clamp.** Set MAX_POS=180 and accept target 250. Required: with `SERVO_RAMP_CLAMP_EN` the ramp ends at 180 with `done_o`; without it the ramp ends at 250.
6. **Null target.** Accept target equal to `position_o` (128). Required: no RAMP, `busy_o` stays 0, `done_o` pulses the next cycle, `target_ready_o` stays 1.
